// File: rtl/multicycle_sequencer_pkg.sv
// Shared state encoding for the multicycle core sequencer.
package multicycle_sequencer_pkg;

   localparam int SEQ_STATE_WIDTH = 3;

   typedef enum logic [SEQ_STATE_WIDTH-1:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5,
      ERROR  = 3'd6
   } seq_state_t;

endpackage

// File: rtl/multicycle_sequencer_wait_timer.sv
// Counts unacknowledged memory-wait cycles; expired flags the last allowed wait cycle.
// TIMEOUT of 0 disables expiry entirely.
module multicycle_sequencer_wait_timer #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expired
);
   localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [W-1:0] wait_cnt_q, wait_cnt_d;

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (clr) begin
         wait_cnt_d = '0;
      end else if (inc) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // An ack in the final wait cycle keeps inc low, so the ack wins over expiry.
   assign expired = (TIMEOUT != 0) && inc && (wait_cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Control FSM stepping each instruction through FETCH/DECODE/EXEC/MEM/WB, with halt and timeout stop.
// Strobes decode from state (irWr/pcIncWr/mdrWr also need the ack); memory requests hold until acked.
module multicycle_sequencer
   import multicycle_sequencer_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       isLoadInsn,
   input  logic                       isStoreInsn,
   input  logic                       isBranch,
   input  logic                       rfWrEnable,
   input  logic                       brTaken,
   input  logic                       halt,
   input  logic                       imemAck,
   input  logic                       dmemAck,
   output logic                       imemReq,
   output logic                       dmemReq,
   output logic                       dmemWrite,
   output logic                       irWr,
   output logic                       pcIncWr,
   output logic                       pcBrWr,
   output logic                       aluOutWr,
   output logic                       mdrWr,
   output logic                       rfWr,
   output logic                       wbSelMem,
   output logic [SEQ_STATE_WIDTH-1:0] state,
   output logic                       retire,
   output logic [CNT_WIDTH-1:0]       insnCount,
   output logic                       error
);
   seq_state_t           state_q, state_d;
   logic [CNT_WIDTH-1:0] insn_cnt_q, insn_cnt_d;
   logic                 retire_c;
   logic                 mem_op;
   logic                 wait_inc;
   logic                 wait_clr;
   logic                 timed_out;

   assign mem_op   = isLoadInsn | isStoreInsn;
   assign wait_inc = ((state_q == FETCH) && !imemAck) || ((state_q == MEM) && !dmemAck);
   assign wait_clr = (state_d != state_q);

   multicycle_sequencer_wait_timer #(
      .TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (wait_clr),
      .inc     (wait_inc),
      .expired (timed_out)
   );

   always_comb begin
      state_d  = state_q;
      retire_c = 1'b0;
      case (state_q)
         FETCH: begin
            if (imemAck) begin
               state_d = DECODE;
            end else if (timed_out) begin
               state_d = ERROR;
            end
         end
         DECODE: state_d = EXEC;
         EXEC: begin
            if (isBranch) begin
               retire_c = 1'b1;
            end else if (mem_op) begin
               state_d = MEM;
            end else if (rfWrEnable) begin
               state_d = WB;
            end else begin
               retire_c = 1'b1;
            end
         end
         MEM: begin
            if (dmemAck) begin
               if (isLoadInsn) begin
                  state_d = WB;
               end else begin
                  retire_c = 1'b1;
               end
            end else if (timed_out) begin
               state_d = ERROR;
            end
         end
         WB:      retire_c = 1'b1;
         HALT: begin
            if (!halt) begin
               state_d = FETCH;
            end
         end
         ERROR:   state_d = ERROR;
         default: state_d = ERROR;
      endcase
      // Every retire is the point where halt is allowed to stop fetching.
      if (retire_c) begin
         state_d = halt ? HALT : FETCH;
      end
   end

   always_comb begin
      insn_cnt_d = insn_cnt_q;
      if (retire_c) begin
         insn_cnt_d = insn_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= FETCH;
         insn_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         insn_cnt_q <= insn_cnt_d;
      end
   end

   // rst is active-low: while it is asserted every request and strobe is forced off.
   always_comb begin
      imemReq   = 1'b0;
      dmemReq   = 1'b0;
      dmemWrite = 1'b0;
      irWr      = 1'b0;
      pcIncWr   = 1'b0;
      pcBrWr    = 1'b0;
      aluOutWr  = 1'b0;
      mdrWr     = 1'b0;
      rfWr      = 1'b0;
      wbSelMem  = 1'b0;
      retire    = 1'b0;
      if (rst) begin
         case (state_q)
            FETCH: begin
               imemReq = 1'b1;
               irWr    = imemAck;
               pcIncWr = imemAck;
            end
            EXEC: begin
               aluOutWr = 1'b1;
               pcBrWr   = isBranch & brTaken;
            end
            MEM: begin
               dmemReq   = 1'b1;
               dmemWrite = isStoreInsn;
               mdrWr     = dmemAck & isLoadInsn;
            end
            WB: begin
               rfWr     = 1'b1;
               wbSelMem = isLoadInsn;
            end
            default: begin
            end
         endcase
         retire = retire_c;
      end
   end

   assign state     = state_q;
   assign insnCount = insn_cnt_q;
   assign error     = (state_q == ERROR);

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Random instruction stream against a per-instruction scoreboard, then directed timeout/reset checks.
module tb_multicycle_sequencer;
   localparam int CW     = 4;
   localparam int TO     = 4;
   localparam int N_INSN = 120;

   logic clk = 1'b0;
   logic rst_n;
   logic isLoadInsn, isStoreInsn, isBranch, rfWrEnable, brTaken, halt, imemAck, dmemAck;
   logic imemReq, dmemReq, dmemWrite, irWr, pcIncWr, pcBrWr, aluOutWr, mdrWr, rfWr, wbSelMem;
   logic retire, error;
   logic [2:0]    state;
   logic [CW-1:0] insnCount;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   multicycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst_n),
      .isLoadInsn(isLoadInsn), .isStoreInsn(isStoreInsn), .isBranch(isBranch),
      .rfWrEnable(rfWrEnable), .brTaken(brTaken), .halt(halt),
      .imemAck(imemAck), .dmemAck(dmemAck),
      .imemReq(imemReq), .dmemReq(dmemReq), .dmemWrite(dmemWrite),
      .irWr(irWr), .pcIncWr(pcIncWr), .pcBrWr(pcBrWr), .aluOutWr(aluOutWr),
      .mdrWr(mdrWr), .rfWr(rfWr), .wbSelMem(wbSelMem), .state(state),
      .retire(retire), .insnCount(insnCount), .error(error)
   );

   typedef struct {
      int lat; int pcbr; int rfwr; int mdr; int dmem; int dmemwr; int wbsel; int cnt;
   } exp_t;

   exp_t sb_q[$];
   exp_t e;

   bit mon_en = 1'b0;
   bit in_insn = 1'b0;
   bit cnt_pend = 1'b0;
   int pend_val = 0;
   int halt_seen = 0;
   int halt_exp = 0;
   int o_lat, o_ir, o_pcinc, o_pcbr, o_rfwr, o_mdr, o_dmem, o_dmemwr, o_wbsel, o_alu;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic rbit();
      return 1'($urandom % 2);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: aggregates what the DUT does over one instruction and scores it at retire.
   always @(negedge clk) begin
      if (mon_en) begin
         if (cnt_pend) begin
            chk("insnCount", int'(insnCount), pend_val);
            cnt_pend = 1'b0;
         end
         if (state == 3'd5) halt_seen++;
         if (!in_insn && state == 3'd0) begin
            in_insn = 1'b1;
            o_lat = 0; o_ir = 0; o_pcinc = 0; o_pcbr = 0; o_rfwr = 0;
            o_mdr = 0; o_dmem = 0; o_dmemwr = 0; o_wbsel = 0; o_alu = 0;
         end
         if (in_insn) begin
            o_lat++;
            o_ir     += int'(irWr);
            o_pcinc  += int'(pcIncWr);
            o_pcbr   += int'(pcBrWr);
            o_rfwr   += int'(rfWr);
            o_mdr    += int'(mdrWr);
            o_dmem   += int'(dmemReq);
            o_dmemwr += int'(dmemReq & dmemWrite);
            o_wbsel  += int'(wbSelMem);
            o_alu    += int'(aluOutWr);
            if (retire) begin
               if (sb_q.size() == 0) begin
                  chk("retire_without_issue", 1, 0);
               end else begin
                  e = sb_q.pop_front();
                  chk("latency", o_lat, e.lat);
                  chk("irWr_pulses", o_ir, 1);
                  chk("pcIncWr_pulses", o_pcinc, 1);
                  chk("aluOutWr_cycles", o_alu, 1);
                  chk("pcBrWr_pulses", o_pcbr, e.pcbr);
                  chk("rfWr_pulses", o_rfwr, e.rfwr);
                  chk("mdrWr_pulses", o_mdr, e.mdr);
                  chk("dmemReq_cycles", o_dmem, e.dmem);
                  chk("dmemWrite_cycles", o_dmemwr, e.dmemwr);
                  chk("wbSelMem_cycles", o_wbsel, e.wbsel);
                  cnt_pend = 1'b1;
                  pend_val = e.cnt;
               end
               in_insn = 1'b0;
            end else if (o_lat > 40) begin
               chk("insn_cycle_budget", o_lat, 40);
               in_insn = 1'b0;
            end
         end
      end
   end

   // kind: 0 ALU, 1 LD, 2 ST, 3 BR, 4 NOP. di/dd are wait cycles before imem/dmem ack.
   task automatic run_insn(input int kind, input int di, input int dd, input bit tk,
                           input bit hlt, input int idx);
      exp_t x;
      bit ld, st, br, rw;
      int h;
      ld = (kind == 1);
      st = (kind == 2);
      br = (kind == 3);
      rw = (kind == 0) || (kind == 1);
      x.lat    = di + 3 + ((ld || st) ? dd + 1 : 0) + (rw ? 1 : 0);
      x.pcbr   = (br && tk) ? 1 : 0;
      x.rfwr   = rw ? 1 : 0;
      x.mdr    = ld ? 1 : 0;
      x.dmem   = (ld || st) ? dd + 1 : 0;
      x.dmemwr = st ? dd + 1 : 0;
      x.wbsel  = ld ? 1 : 0;
      x.cnt    = idx % (1 << CW);
      sb_q.push_back(x);
      for (int k = 0; k <= di; k++) begin
         imemAck = (k == di);
         dmemAck = rbit();
         halt    = rbit();
         {isLoadInsn, isStoreInsn, isBranch, rfWrEnable} = 4'($urandom);
         brTaken = rbit();
         tick();
      end
      imemAck = rbit(); dmemAck = rbit();
      isLoadInsn = ld; isStoreInsn = st; isBranch = br; rfWrEnable = rw;
      tick();
      imemAck = rbit(); dmemAck = rbit();
      brTaken = br ? tk : rbit();
      halt    = hlt;
      tick();
      if (ld || st) begin
         for (int k = 0; k <= dd; k++) begin
            dmemAck = (k == dd);
            imemAck = rbit();
            tick();
         end
      end
      if (rw) begin
         imemAck = rbit(); dmemAck = rbit();
         tick();
      end
      if (hlt) begin
         h = $urandom % 3;
         halt_exp += h + 1;
         for (int k = 0; k < h; k++) begin
            imemAck = rbit(); dmemAck = rbit();
            tick();
         end
         halt = 1'b0;
         tick();
      end
      halt = 1'b0;
   endtask

   initial begin
      int n, wr;
      bit got;
      rst_n = 1'b0;
      imemAck = 1'b1; dmemAck = 1'b1; halt = 1'b0; brTaken = 1'b1;
      isLoadInsn = 1'b1; isStoreInsn = 1'b0; isBranch = 1'b0; rfWrEnable = 1'b1;
      #2;
      chk("reset_state", int'(state), 0);
      chk("reset_imemReq", int'(imemReq), 0);
      chk("reset_irWr", int'(irWr), 0);
      chk("reset_insnCount", int'(insnCount), 0);
      chk("reset_error", int'(error), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;

      for (int i = 0; i < N_INSN; i++) begin
         int kind, di, dd;
         kind = $urandom % 5;
         di   = ($urandom % 3 == 0) ? 0 : $urandom % TO;
         dd   = ($urandom % 3 == 0) ? 0 : $urandom % TO;
         run_insn(kind, di, dd, rbit(), ($urandom % 6 == 0), i + 1);
      end

      imemAck = 1'b0; dmemAck = 1'b0; halt = 1'b0;
      repeat (2) @(negedge clk);
      mon_en = 1'b0;
      chk("scoreboard_drained", sb_q.size(), 0);
      chk("halt_cycles", halt_seen, halt_exp);

      // Instruction fetch never acknowledged.
      rst_n = 1'b0;
      #1;
      chk("reset2_state", int'(state), 0);
      chk("reset2_insnCount", int'(insnCount), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n = 0; got = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (state == 3'd6) begin
            got = 1'b1;
            break;
         end
         if (imemReq) n++;
      end
      chk("fetch_timeout_reached", int'(got), 1);
      chk("fetch_timeout_req_cycles", n, TO);
      imemAck = 1'b1; dmemAck = 1'b1; halt = 1'b1;
      repeat (3) @(negedge clk);
      chk("error_sticky_state", int'(state), 6);
      chk("error_flag", int'(error), 1);
      chk("error_outputs_quiet",
          int'({imemReq, dmemReq, dmemWrite, irWr, pcIncWr, pcBrWr, aluOutWr, mdrWr, rfWr, wbSelMem, retire}), 0);
      rst_n = 1'b0;
      halt  = 1'b0;
      #1;
      chk("reset3_error", int'(error), 0);
      chk("reset3_state", int'(state), 0);

      // Load whose data memory request is never acknowledged.
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      imemAck = 1'b1; dmemAck = 1'b0;
      tick();
      imemAck = 1'b0;
      isLoadInsn = 1'b1; isStoreInsn = 1'b0; isBranch = 1'b0; rfWrEnable = 1'b1;
      tick();
      tick();
      n = 0; wr = 0; got = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (state == 3'd6) begin
            got = 1'b1;
            break;
         end
         if (dmemReq) n++;
         if (dmemWrite) wr++;
      end
      chk("mem_timeout_reached", int'(got), 1);
      chk("mem_timeout_req_cycles", n, TO);
      chk("mem_timeout_load_write", wr, 0);
      chk("mem_timeout_error", int'(error), 1);
      rst_n = 1'b0;
      #1;
      chk("reset4_error", int'(error), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
